mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage plus MEM/WB pipeline register for the 5-stage RV32I core. Consumes the EX/MEM register outputs, runs the data-memory read/write handshake (byte enables, store-data lane shifting, load alignment and sign/zero extension), stalls the pipeline while a memory access is outstanding, and presents registered results to the writeback stage.

## Interface
Parameters:
- none (fixed 32-bit datapath)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- load  in  1  global advance enable from the hazard unit
- control_word_in  in  rv32i_control_word  from EX/MEM (uses opcode, mem_read, mem_write, funct3, rd)
- alu_in  in  32  ALU result from EX/MEM
- mar_in  in  32  byte address from EX/MEM
- mem_wdata_in  in  32  unshifted rs2 store data
- br_en_in  in  1  branch compare result
- imm_in  in  packed_imm  immediates
- dmem_resp  in  1  data memory done pulse
- dmem_rdata  in  32  data memory read word
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_address  out  32  {mar[31:2],2'b00}
- dmem_wdata  out  32  lane-shifted store data
- dmem_byte_enable  out  4  store byte mask
- stall_out  out  1  freezes PC, IF/ID, ID/EX, EX/MEM
- control_word_out  out  rv32i_control_word  MEM/WB copy
- alu_out, mar_out  out  32  MEM/WB copies
- mdr_out  out  32  aligned, extended load data
- br_en_out  out  1; imm_out  out  packed_imm  MEM/WB copies

## Operation
- FSM states: IDLE, REQ, DONE. Reset → IDLE.
- IDLE: if control_word_in.mem_read or mem_write → REQ next edge; else no request.
- REQ: dmem_read/dmem_write driven from registered copies of the control bits; address/wdata/byte_enable held stable. On dmem_resp: latch dmem_rdata into internal rdata register; → IDLE if load=1, else → DONE.
- DONE: hold latched data, no request; → IDLE when load=1.
- stall_out = (IDLE & mem op) | (REQ & !dmem_resp). Non-memory ops never stall.
- MEM/WB register loads when load & !stall_out; otherwise holds.
- Byte offset off = mar_in[1:0]. Stores: sb → enable 4'b0001<<off, wdata = rs2<<(8*off); sh → 4'b0011<<{off[1],1'b0}, wdata = rs2<<(16*off[1]); sw → 4'b1111, unshifted. Misaligned sh/sw: off low bits ignored, no trap.
- Loads (funct3): lb/lbu select byte off, lh/lhu select half off[1]; sign-extend for lb/lh, zero-extend for lbu/lhu; lw passthrough. Loads drive byte_enable 4'b0000.
- Load data used in REQ-with-resp is dmem_rdata directly; in DONE the latched copy.
- dmem_resp in IDLE/DONE ignored.

## Timing
- Reset (async): state IDLE; dmem_read, dmem_write, stall_out (when no mem op), all MEM/WB outputs, byte_enable = 0; control_word_out all fields 0.
- Non-memory op: 1 cycle through MEM/WB.
- Memory op, zero-wait memory: request asserted cycle after op arrives; minimum 2 cycles in stage.
- Request held until dmem_resp; deasserted the edge after resp.
- Reset mid-REQ: request dropped immediately, pending data discarded.
- Back-to-back memory ops: second op re-enters REQ via IDLE; one idle cycle between requests.

## Structure
- rv32i_types: add mem_stage_state_t enum {IDLE, REQ, DONE}; funct3 constants for lb/lh/lw/lbu/lhu/sb/sh/sw if not present.
- Sub-module mem_align: combinational store lane shift/byte-enable and load extract/extend.

## Test plan
- ALU op rd=5, alu_in=0x1234, load=1 → next edge alu_out=0x1234, no dmem request, stall_out=0.
- sw mar=0x100, rs2=0xDEADBEEF, resp after 3 cycles → dmem_write for 3 cycles, enable 4'b1111, address 0x100, stall_out high until resp.
- sb mar=0x103, rs2=0x000000AB → enable 4'b1000, dmem_wdata=0xAB000000.
- lb mar=0x102, rdata=0x00800000 → mdr_out=0xFFFFFF80; lbu same → 0x00000080; lh mar=0x102, rdata=0x80010000 → 0xFFFF8001.
- lw resp while load=0 → state DONE, data held; load=1 two cycles later → mdr_out=rdata, state IDLE.
- rst asserted mid-REQ → dmem_read drops same cycle, all outputs 0, state IDLE.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared RV32I types for the memory-access stage.
//   rv32i_opcode       : base opcode encodings
//   rv32i_control_word : control bundle carried down the pipeline registers
//   packed_imm         : all immediate formats produced by decode
//   mem_stage_state_t  : memory-stage handshake FSM states
//   F3_*               : load/store width selectors carried in funct3
package mem_stage_pkg;

    typedef enum logic [6:0] {
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111,
        OP_JAL   = 7'b1101111,
        OP_JALR  = 7'b1100111,
        OP_BR    = 7'b1100011,
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011,
        OP_IMM   = 7'b0010011,
        OP_REG   = 7'b0110011,
        OP_CSR   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        mem_read;
        logic        mem_write;
        logic        load_regfile;
        logic [4:0]  rd;
    } rv32i_control_word;

    typedef struct packed {
        logic [31:0] i_imm;
        logic [31:0] s_imm;
        logic [31:0] b_imm;
        logic [31:0] u_imm;
        logic [31:0] j_imm;
    } packed_imm;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_stage_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/mem_align.sv
// Combinational data-lane alignment for the memory stage.
//   funct3      : access width / signedness
//   offset      : byte offset within the word (address bits [1:0])
//   store_data  : unshifted rs2 value
//   load_word   : full word returned by data memory
//   wdata       : store data shifted onto its byte lanes
//   byte_enable : store byte mask (caller gates it off for loads)
//   load_data   : selected, sign/zero-extended load result
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] wdata,
    output logic [3:0]  byte_enable,
    output logic [31:0] load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Misaligned halfword/word accesses silently drop the low offset bits.
    always_comb begin
        wdata       = store_data;
        byte_enable = 4'b1111;
        case (funct3)
            F3_SB: begin
                byte_enable = 4'b0001 << offset;
                wdata       = store_data << {offset, 3'b000};
            end
            F3_SH: begin
                byte_enable = 4'b0011 << {offset[1], 1'b0};
                wdata       = store_data << {offset[1], 4'b0000};
            end
            default: begin
                wdata       = store_data;
                byte_enable = 4'b1111;
            end
        endcase
    end

    always_comb begin
        sel_byte  = load_word[{offset, 3'b000} +: 8];
        sel_half  = load_word[{offset[1], 4'b0000} +: 16];
        load_data = load_word;
        case (funct3)
            F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  load_data = {24'h000000, sel_byte};
            F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            F3_LHU:  load_data = {16'h0000, sel_half};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage and MEM/WB pipeline register of the RV32I core.
//   clk, rst            : clock, asynchronous active-high reset
//   load                : global advance enable from the hazard unit
//   control_word_in ... : EX/MEM register outputs
//   dmem_*              : data memory request/response port
//   stall_out           : freezes upstream stages while an access is outstanding
//   *_out               : MEM/WB register contents
//   debug_state         : current handshake FSM state
//
// Handshake: a request (dmem_read or dmem_write) is raised from registered
// copies of the op and held, with address, data and byte enables stable,
// until the cycle dmem_resp is seen high; it drops on the following edge.
// dmem_resp outside REQ is ignored.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  rv32i_control_word control_word_in,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       mar_in,
    input  logic [31:0]       mem_wdata_in,
    input  logic              br_en_in,
    input  packed_imm         imm_in,
    input  logic              dmem_resp,
    input  logic [31:0]       dmem_rdata,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [31:0]       dmem_address,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_byte_enable,
    output logic              stall_out,
    output rv32i_control_word control_word_out,
    output logic [31:0]       alu_out,
    output logic [31:0]       mar_out,
    output logic [31:0]       mdr_out,
    output logic              br_en_out,
    output packed_imm         imm_out,
    output mem_stage_state_t  debug_state
);

    mem_stage_state_t state, state_next;

    logic        mem_op;
    logic        launch;
    logic        resp_seen;
    logic        wb_load;
    logic [31:0] rdata_q;
    logic [31:0] load_word;
    logic [31:0] align_wdata;
    logic [3:0]  align_be;
    logic [31:0] align_load;

    assign mem_op    = control_word_in.mem_read | control_word_in.mem_write;
    assign launch    = (state == IDLE) && mem_op;
    assign resp_seen = (state == REQ) && dmem_resp;
    assign wb_load   = load && !stall_out;

    // Same-cycle response uses the bus directly; once parked in DONE the
    // bus may change, so the latched copy is used instead.
    assign load_word   = (state == DONE) ? rdata_q : dmem_rdata;
    assign debug_state = state;

    mem_align u_align (
        .funct3      (control_word_in.funct3),
        .offset      (mar_in[1:0]),
        .store_data  (mem_wdata_in),
        .load_word   (load_word),
        .wdata       (align_wdata),
        .byte_enable (align_be),
        .load_data   (align_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall_out  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    state_next = REQ;
                    stall_out  = 1'b1;
                end
            end
            REQ: begin
                if (dmem_resp) begin
                    state_next = load ? IDLE : DONE;
                end else begin
                    stall_out = 1'b1;
                end
            end
            DONE: begin
                if (load) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request registers: captured on entry to REQ, request strobes and byte
    // enables cleared on the edge after the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_address     <= 32'h0;
            dmem_wdata       <= 32'h0;
            dmem_byte_enable <= 4'h0;
        end else if (launch) begin
            dmem_read        <= control_word_in.mem_read;
            dmem_write       <= control_word_in.mem_write;
            dmem_address     <= {mar_in[31:2], 2'b00};
            dmem_wdata       <= align_wdata;
            dmem_byte_enable <= control_word_in.mem_write ? align_be : 4'h0;
        end else if (resp_seen) begin
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_byte_enable <= 4'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'h0;
        end else if (resp_seen) begin
            rdata_q <= dmem_rdata;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            control_word_out <= '0;
            alu_out          <= 32'h0;
            mar_out          <= 32'h0;
            mdr_out          <= 32'h0;
            br_en_out        <= 1'b0;
            imm_out          <= '0;
        end else if (wb_load) begin
            control_word_out <= control_word_in;
            alu_out          <= alu_in;
            mar_out          <= mar_in;
            mdr_out          <= align_load;
            br_en_out        <= br_en_in;
            imm_out          <= imm_in;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              load;
    rv32i_control_word control_word_in;
    logic [31:0]       alu_in, mar_in, mem_wdata_in;
    logic              br_en_in;
    packed_imm         imm_in;
    logic              dmem_resp;
    logic [31:0]       dmem_rdata;
    logic              dmem_read, dmem_write;
    logic [31:0]       dmem_address, dmem_wdata;
    logic [3:0]        dmem_byte_enable;
    logic              stall_out;
    rv32i_control_word control_word_out;
    logic [31:0]       alu_out, mar_out, mdr_out;
    logic              br_en_out;
    packed_imm         imm_out;
    mem_stage_state_t  debug_state;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .load             (load),
        .control_word_in  (control_word_in),
        .alu_in           (alu_in),
        .mar_in           (mar_in),
        .mem_wdata_in     (mem_wdata_in),
        .br_en_in         (br_en_in),
        .imm_in           (imm_in),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .stall_out        (stall_out),
        .control_word_out (control_word_out),
        .alu_out          (alu_out),
        .mar_out          (mar_out),
        .mdr_out          (mdr_out),
        .br_en_out        (br_en_out),
        .imm_out          (imm_out),
        .debug_state      (debug_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wb_alu;   // expected alu_out held in MEM/WB

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] mar);
        int off;
        off = int'(mar % 4);
        case (f3)
            3'd0:    return 4'(1 << off);
            3'd1:    return 4'(3 << ((off / 2) * 2));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] mar,
                                                input logic [31:0] rs2);
        longint v;
        int off;
        off = int'(mar % 4);
        v = longint'(rs2);
        case (f3)
            3'd0:    v = v * (longint'(1) << (8 * off));
            3'd1:    v = v * (longint'(1) << (16 * (off / 2)));
            default: v = v;
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] mar,
                                               input logic [31:0] word);
        longint b, h, v;
        int off;
        off = int'(mar % 4);
        b = longint'(word >> (8 * off)) % 256;
        h = longint'(word >> (16 * (off / 2))) % 65536;
        case (f3)
            3'd0:    v = (b >= 128) ? b - 256 : b;
            3'd4:    v = b;
            3'd1:    v = (h >= 32768) ? h - 65536 : h;
            3'd5:    v = h;
            default: v = longint'(word);
        endcase
        return v[31:0];
    endfunction

    function automatic rv32i_control_word make_cw(input logic is_load, input logic is_store,
                                                  input logic [2:0] f3, input logic [4:0] rd);
        rv32i_control_word cw;
        cw              = '0;
        cw.opcode       = is_load ? OP_LOAD : (is_store ? OP_STORE : OP_IMM);
        cw.funct3       = f3;
        cw.mem_read     = is_load;
        cw.mem_write    = is_store;
        cw.load_regfile = !is_store;
        cw.rd           = is_store ? 5'd0 : rd;
        return cw;
    endfunction

    // ---------------- driver tasks ----------------
    // Non-memory op: passes through MEM/WB in one cycle when load=1, held otherwise.
    task automatic alu_op(input string tag, input logic [31:0] alu, input logic [4:0] rd,
                          input logic ld);
        logic br;
        logic [31:0] imm_i;
        br    = 1'($urandom_range(0, 1));
        imm_i = $urandom;
        @(posedge clk); #1;
        control_word_in = make_cw(1'b0, 1'b0, 3'd0, rd);
        alu_in = alu; mar_in = $urandom; br_en_in = br;
        imm_in = '0; imm_in.i_imm = imm_i;
        dmem_resp = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
        load = ld;
        exp_q.push_back(ld ? alu : wb_alu);
        @(negedge clk);
        check1({tag, " stall"}, stall_out, 1'b0);
        check1({tag, " no_read"}, dmem_read, 1'b0);
        check1({tag, " no_write"}, dmem_write, 1'b0);
        @(posedge clk); #1;
        load = 1'b0;
        @(negedge clk);
        wb_alu = exp_q.pop_front();
        check32({tag, " alu_out"}, alu_out, wb_alu);
        if (ld) begin
            check32({tag, " rd_out"}, {27'd0, control_word_out.rd}, {27'd0, rd});
            check1({tag, " br_en_out"}, br_en_out, br);
            check32({tag, " imm_out"}, imm_out.i_imm, imm_i);
        end
        check32({tag, " state"}, {30'd0, debug_state}, {30'd0, IDLE});
    endtask

    // Memory op: one IDLE cycle, resp_delay REQ cycles (response in the last),
    // then hold DONE cycles with load=0 and one DONE cycle with load=1.
    task automatic run_mem(input string tag, input logic is_store, input logic [2:0] f3,
                           input logic [31:0] mar, input logic [31:0] rs2,
                           input logic [31:0] rdata, input int resp_delay, input int hold,
                           input logic [3:0] e_be, input logic [31:0] e_wdata,
                           input logic [31:0] e_mdr);
        logic [4:0]  rd;
        logic [31:0] alu;
        rd  = 5'($urandom_range(1, 31));
        alu = $urandom;
        @(posedge clk); #1;
        control_word_in = make_cw(!is_store, is_store, f3, rd);
        alu_in = alu; mar_in = mar; mem_wdata_in = rs2;
        dmem_resp = 1'b0; dmem_rdata = $urandom; load = 1'b1;
        @(negedge clk);
        check1({tag, " idle_stall"}, stall_out, 1'b1);
        check1({tag, " idle_no_read"}, dmem_read, 1'b0);
        check1({tag, " idle_no_write"}, dmem_write, 1'b0);
        for (int k = 1; k <= resp_delay; k++) begin
            @(posedge clk); #1;
            if (k == resp_delay) begin
                dmem_resp = 1'b1; dmem_rdata = rdata; load = (hold == 0);
            end else begin
                dmem_resp = 1'b0; dmem_rdata = $urandom; load = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check32({tag, " state_req"}, {30'd0, debug_state}, {30'd0, REQ});
            check1({tag, " read"}, dmem_read, !is_store);
            check1({tag, " write"}, dmem_write, is_store);
            check32({tag, " address"}, dmem_address, mar & 32'hFFFF_FFFC);
            check32({tag, " byte_enable"}, {28'd0, dmem_byte_enable}, {28'd0, e_be});
            if (is_store) check32({tag, " wdata"}, dmem_wdata, e_wdata);
            check1({tag, " req_stall"}, stall_out, k != resp_delay);
        end
        for (int h = 0; h <= hold; h++) begin
            if (hold == 0) break;
            @(posedge clk); #1;
            dmem_resp = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
            load = (h == hold);
            @(negedge clk);
            check32({tag, " state_done"}, {30'd0, debug_state}, {30'd0, DONE});
            check1({tag, " done_no_read"}, dmem_read, 1'b0);
            check1({tag, " done_no_write"}, dmem_write, 1'b0);
            check1({tag, " done_stall"}, stall_out, 1'b0);
            check32({tag, " done_wb_held"}, alu_out, wb_alu);
        end
        @(posedge clk); #1;
        control_word_in = make_cw(1'b0, 1'b0, 3'd0, 5'd0);
        dmem_resp = 1'b0; load = 1'b0;
        @(negedge clk);
        wb_alu = alu;
        check32({tag, " state_end"}, {30'd0, debug_state}, {30'd0, IDLE});
        check1({tag, " end_no_read"}, dmem_read, 1'b0);
        check1({tag, " end_no_write"}, dmem_write, 1'b0);
        check32({tag, " alu_out"}, alu_out, alu);
        check32({tag, " mar_out"}, mar_out, mar);
        check32({tag, " rd_out"}, {27'd0, control_word_out.rd}, {27'd0, is_store ? 5'd0 : rd});
        if (!is_store) check32({tag, " mdr_out"}, mdr_out, e_mdr);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        string       tag;
        logic        is_store;
        logic [2:0]  f3;
        logic [31:0] mar;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          resp_delay;
        int          hold;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] mdr;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{"sw_0x100",  1'b1, 3'd0 + F3_SW,  32'h100, 32'hDEADBEEF, 32'h0,        3, 0, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{"sb_0x103",  1'b1, 3'd0 + F3_SB,  32'h103, 32'h000000AB, 32'h0,        1, 0, 4'b1000, 32'hAB000000, 32'h0};
        vecs[2]  = '{"lb_0x102",  1'b0, 3'd0 + F3_LB,  32'h102, 32'h0,        32'h00800000, 1, 0, 4'b0000, 32'h0,        32'hFFFFFF80};
        vecs[3]  = '{"lbu_0x102", 1'b0, 3'd0 + F3_LBU, 32'h102, 32'h0,        32'h00800000, 1, 0, 4'b0000, 32'h0,        32'h00000080};
        vecs[4]  = '{"lh_0x102",  1'b0, 3'd0 + F3_LH,  32'h102, 32'h0,        32'h80010000, 2, 0, 4'b0000, 32'h0,        32'hFFFF8001};
        vecs[5]  = '{"lw_done",   1'b0, 3'd0 + F3_LW,  32'h204, 32'h0,        32'hCAFEF00D, 2, 1, 4'b0000, 32'h0,        32'hCAFEF00D};
        vecs[6]  = '{"sh_0x106",  1'b1, 3'd0 + F3_SH,  32'h106, 32'h0000BEEF, 32'h0,        1, 0, 4'b1100, 32'hBEEF0000, 32'h0};
        vecs[7]  = '{"sh_mis",    1'b1, 3'd0 + F3_SH,  32'h101, 32'h00001234, 32'h0,        2, 0, 4'b0011, 32'h00001234, 32'h0};
        vecs[8]  = '{"lhu_0x100", 1'b0, 3'd0 + F3_LHU, 32'h100, 32'h0,        32'h1234F00D, 1, 2, 4'b0000, 32'h0,        32'h0000F00D};
        vecs[9]  = '{"sw_mis",    1'b1, 3'd0 + F3_SW,  32'h103, 32'h01020304, 32'h0,        1, 1, 4'b1111, 32'h01020304, 32'h0};
        vecs[10] = '{"lb_pos",    1'b0, 3'd0 + F3_LB,  32'h101, 32'h0,        32'h00007F00, 1, 0, 4'b0000, 32'h0,        32'h0000007F};

        // reset state
        rst = 1'b1; load = 1'b0;
        control_word_in = make_cw(1'b0, 1'b0, 3'd0, 5'd0);
        alu_in = 32'h0; mar_in = 32'h0; mem_wdata_in = 32'h0; br_en_in = 1'b0; imm_in = '0;
        dmem_resp = 1'b0; dmem_rdata = 32'h0;
        wb_alu = 32'h0;
        repeat (2) @(negedge clk);
        check32("reset state", {30'd0, debug_state}, {30'd0, IDLE});
        check1("reset read", dmem_read, 1'b0);
        check1("reset write", dmem_write, 1'b0);
        check32("reset byte_enable", {28'd0, dmem_byte_enable}, 32'h0);
        check1("reset stall", stall_out, 1'b0);
        check32("reset alu_out", alu_out, 32'h0);
        check32("reset mar_out", mar_out, 32'h0);
        check32("reset mdr_out", mdr_out, 32'h0);
        check1("reset br_en_out", br_en_out, 1'b0);
        check1("reset cw_out_zero", control_word_out != '0, 1'b0);
        check1("reset imm_out_zero", imm_out != '0, 1'b0);
        rst = 1'b0;

        alu_op("alu_rd5", 32'h1234, 5'd5, 1'b1);
        alu_op("alu_hold", 32'h5555, 5'd7, 1'b0);

        for (int i = 0; i < 11; i++) begin
            run_mem(vecs[i].tag, vecs[i].is_store, vecs[i].f3, vecs[i].mar, vecs[i].rs2,
                    vecs[i].rdata, vecs[i].resp_delay, vecs[i].hold,
                    vecs[i].be, vecs[i].wdata, vecs[i].mdr);
        end

        // back-to-back memory ops with no gap in the op stream
        run_mem("b2b_a", 1'b0, F3_LW, 32'h300, 32'h0, 32'h11112222, 1, 0, 4'h0, 32'h0, 32'h11112222);
        run_mem("b2b_b", 1'b1, F3_SW, 32'h304, 32'h33334444, 32'h0, 1, 0, 4'hF, 32'h33334444, 32'h0);

        // randomized mix against the reference model
        for (int n = 0; n < 40; n++) begin
            int kind;
            logic [2:0]  f3;
            logic [31:0] mar, rs2, rdata;
            kind  = int'($urandom_range(0, 2));
            mar   = $urandom;
            rs2   = $urandom;
            rdata = $urandom;
            if (kind == 0) begin
                alu_op("rnd_alu", $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end else if (kind == 1) begin
                case ($urandom_range(0, 4))
                    0: f3 = F3_LB;
                    1: f3 = F3_LH;
                    2: f3 = F3_LW;
                    3: f3 = F3_LBU;
                    default: f3 = F3_LHU;
                endcase
                run_mem("rnd_load", 1'b0, f3, mar, rs2, rdata, int'($urandom_range(1, 4)),
                        int'($urandom_range(0, 2)), 4'h0, 32'h0, model_load(f3, mar, rdata));
            end else begin
                f3 = 3'($urandom_range(0, 2));
                run_mem("rnd_store", 1'b1, f3, mar, rs2, rdata, int'($urandom_range(1, 4)),
                        int'($urandom_range(0, 2)), model_be(f3, mar), model_wdata(f3, mar, rs2),
                        32'h0);
            end
        end

        // reset asserted while a read is outstanding
        @(posedge clk); #1;
        control_word_in = make_cw(1'b1, 1'b0, F3_LW, 5'd9);
        alu_in = 32'hA5A5A5A5; mar_in = 32'h400; dmem_resp = 1'b0; load = 1'b1;
        @(posedge clk); #1;
        check1("rstmid pre_read", dmem_read, 1'b1);
        #2;
        rst = 1'b1;
        control_word_in = make_cw(1'b0, 1'b0, 3'd0, 5'd0);
        #1;
        check1("rstmid read_drop", dmem_read, 1'b0);
        check32("rstmid state", {30'd0, debug_state}, {30'd0, IDLE});
        check1("rstmid stall", stall_out, 1'b0);
        check32("rstmid alu_out", alu_out, 32'h0);
        check32("rstmid mdr_out", mdr_out, 32'h0);
        check1("rstmid cw_out_zero", control_word_out != '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wb_alu = 32'h0;
        @(negedge clk);
        check1("rstmid after read", dmem_read, 1'b0);
        check32("rstmid after state", {30'd0, debug_state}, {30'd0, IDLE});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
